// File: rtl/dmem_mmio.sv
// dmem_mmio -- data-side memory stage for the single-cycle core.
//
// Holds a word-addressed data RAM and a small MMIO window containing a
// TX FIFO (drained through a valid/ready port), a status register and an
// optional free-running cycle counter. Loads are combinational, so the core
// completes a load in the same cycle. Stores commit on the rising clock edge.
//
// Optional feature macro: DMEM_CYCLE_CNT_EN
//    defined   -> 32-bit cycle counter present, readable at MMIO_BASE+8
//    undefined -> no counter register; MMIO_BASE+8 reads 32'b0
//
// Address map:
//    0 .. RAM_WORDS*4-1 : data RAM (word access, addr[1:0] ignored)
//    MMIO_BASE+0        : TXDATA (write pushes into the FIFO, reads 0)
//    MMIO_BASE+4        : STATUS {16'b0, count[7:0], 5'b0, overflow, full, empty}
//                         (write with bit 2 set clears overflow)
//    MMIO_BASE+8        : CYCLE (read-only)
//    anything else      : reads 0, writes ignored
//
// Ports:
//    clk            : single clock, rising-edge
//    reset          : asynchronous, active-low reset
//    WE             : store enable from the core
//    address_to_mem : byte address from the core
//    data_to_mem    : store data from the core
//    data_from_mem  : combinational load data to the core
//    tx_valid       : FIFO head is valid
//    tx_data        : FIFO head word (0 while empty)
//    tx_ready       : consumer accepts the head word
//    tx_overflow    : sticky flag, a push was dropped because the FIFO was full

module dmem_mmio #(
   parameter int unsigned RAM_WORDS  = 256,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WE,
   input  logic [31:0] address_to_mem,
   input  logic [31:0] data_to_mem,
   output logic [31:0] data_from_mem,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   input  logic        tx_ready,
   output logic        tx_overflow
);

   localparam int unsigned IDX_W = $clog2(RAM_WORDS);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [31:0]      RAM_BYTES   = 32'(RAM_WORDS * 4);
   localparam logic [31:0]      ADDR_TXDATA = MMIO_BASE;
   localparam logic [31:0]      ADDR_STATUS = MMIO_BASE + 32'd4;
   localparam logic [31:0]      ADDR_CYCLE  = MMIO_BASE + 32'd8;
   localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

   // Address decode; the RAM region takes priority over the MMIO window.
   logic             sel_ram;
   logic             sel_txdata;
   logic             sel_status;
   logic             sel_cycle;
   logic [IDX_W-1:0] ram_idx;

   assign sel_ram    = (address_to_mem < RAM_BYTES);
   assign sel_txdata = !sel_ram && (address_to_mem == ADDR_TXDATA);
   assign sel_status = !sel_ram && (address_to_mem == ADDR_STATUS);
   assign sel_cycle  = !sel_ram && (address_to_mem == ADDR_CYCLE);
   assign ram_idx    = address_to_mem[IDX_W+1:2];

   // Data RAM: contents are intentionally not reset.
   logic [31:0] ram [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (WE && sel_ram) begin
         ram[ram_idx] <= data_to_mem;
      end
   end

   // TX FIFO state.
   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             overflow;

   logic full;
   logic empty;
   logic push_req;
   logic pop;
   logic push_ok;
   logic drop;
   logic clear_ovf;

   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign pop       = !empty && tx_ready;
   assign push_req  = WE && sel_txdata;
   // A pop in the same cycle frees a slot, so a push into a full FIFO
   // still succeeds when the consumer is taking the head.
   assign push_ok   = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;
   assign clear_ovf = WE && sel_status && data_to_mem[2];

   // Pointer, occupancy and sticky overflow update. Pointers wrap naturally
   // because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) begin
            head <= head + 1'b1;
         end
         if (push_ok) begin
            tail <= tail + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (clear_ovf) begin
            overflow <= 1'b0;
         end else if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // FIFO storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[tail] <= data_to_mem;
      end
   end

   // tx_data is forced to zero while empty so it is well defined in reset.
   assign tx_valid    = !empty;
   assign tx_data     = empty ? 32'b0 : fifo_mem[head];
   assign tx_overflow = overflow;

   // Cycle counter (optional).
   logic [31:0] cycle_val;

`ifdef DMEM_CYCLE_CNT_EN
   logic [31:0] cycle_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   assign cycle_val = cycle_cnt;
`else
   assign cycle_val = 32'b0;
`endif

   // Status word; count is zero-extended into an 8-bit field.
   logic [7:0]  count8;
   logic [31:0] status_word;

   assign count8      = 8'(count);
   assign status_word = {16'b0, count8, 5'b0, overflow, full, empty};

   // Combinational load mux. TXDATA and unmapped addresses fall through to 0.
   always_comb begin
      data_from_mem = 32'b0;
      if (sel_ram) begin
         data_from_mem = ram[ram_idx];
      end else if (sel_status) begin
         data_from_mem = status_word;
      end else if (sel_cycle) begin
         data_from_mem = cycle_val;
      end
   end

endmodule
